// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, data (LSB first), optional parity,
// one or two stop bits; sequences the external bit serializer.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int DONE_TIMEOUT = DATA_WIDTH + 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DATA_VALID,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  READY,
  output logic                  FRAME_ERR
);

  localparam int CW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t          state_q, state_d;
  logic            par_en_q, par_en_d;
  logic            stop2_q, stop2_d;
  logic            par_bit_q, par_bit_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            timeout;

  always_comb begin
    READY = 1'b0;
    unique case (state_q)
      S_IDLE:  READY = 1'b1;
      S_STOP1: READY = ~stop2_q;
      S_STOP2: READY = 1'b1;
      default: READY = 1'b0;
    endcase
  end

  assign accept  = DATA_VALID & READY;
  assign timeout = (cnt_q == CW'(DONE_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    par_bit_d = par_bit_q;
    cnt_d     = '0;
    err_d     = 1'b0;
    if (accept) begin
      par_en_d  = PAR_EN;
      stop2_d   = STOP2;
      par_bit_d = ^P_DATA ^ PAR_TYP;
    end
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: state_d = S_DATA;
      S_DATA: begin
        // ser_done has priority over the timeout abort
        if (ser_done) begin
          state_d = par_en_q ? S_PARITY : S_STOP1;
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: state_d = S_STOP1;
      S_STOP1: begin
        if (stop2_q)     state_d = S_STOP2;
        else if (accept) state_d = S_START;
        else             state_d = S_IDLE;
      end
      S_STOP2: state_d = accept ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    TX_OUT = 1'b1;
    ser_en = 1'b0;
    unique case (state_q)
      S_START: begin
        TX_OUT = 1'b0;
        ser_en = 1'b1;
      end
      S_DATA: begin
        TX_OUT = ser_data;
        ser_en = 1'b1;
      end
      S_PARITY: TX_OUT = par_bit_q;
      default:  TX_OUT = 1'b1;
    endcase
  end

  assign BUSY      = (state_q != S_IDLE);
  assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: serializer model plus a TX bit scoreboard
// sampled just after each rising edge.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       DATA_VALID;
  logic [7:0] P_DATA;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic       ser_done;
  logic       ser_data;
  logic       ser_en;
  logic       TX_OUT;
  logic       BUSY;
  logic       READY;
  logic       FRAME_ERR;

  int   checks = 0;
  int   passes = 0;
  logic exp_q[$];
  bit   mon_en = 1'b1;
  logic mon_e;

  logic [7:0] ser_latch;
  logic [7:0] ser_sh;
  logic [2:0] ser_idx;
  logic       ser_busy;
  bit         no_done = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_VALID (DATA_VALID),
    .P_DATA     (P_DATA),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .READY      (READY),
    .FRAME_ERR  (FRAME_ERR)
  );

  // Serializer: loads its own copy on the first enabled edge, then shifts.
  assign ser_done = ser_busy && (ser_idx == 3'd7) && !no_done;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ser_latch <= 8'h00;
      ser_sh    <= 8'h00;
      ser_idx   <= 3'd0;
      ser_busy  <= 1'b0;
      ser_data  <= 1'b1;
    end else begin
      if (DATA_VALID && READY) ser_latch <= P_DATA;
      if (!ser_en) begin
        ser_busy <= 1'b0;
      end else if (!ser_busy) begin
        ser_busy <= 1'b1;
        ser_idx  <= 3'd0;
        ser_sh   <= ser_latch;
        ser_data <= ser_latch[0];
      end else if (ser_idx == 3'd7) begin
        ser_busy <= 1'b0;
      end else begin
        ser_idx  <= ser_idx + 3'd1;
        ser_data <= ser_sh[ser_idx + 3'd1];
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (mon_en) begin
        checks++;
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          if (TX_OUT !== mon_e || BUSY !== 1'b1)
            $display("FAIL frame_bit t=%0t tx=%b busy=%b want tx=%b busy=1",
                     $time, TX_OUT, BUSY, mon_e);
          else passes++;
        end else begin
          if (TX_OUT !== 1'b1 || BUSY !== 1'b0)
            $display("FAIL idle_line t=%0t tx=%b busy=%b want tx=1 busy=0",
                     $time, TX_OUT, BUSY);
          else passes++;
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] d, input logic pe,
                            input logic pt, input logic s2);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(^d ^ pt);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  task automatic push_bits(input logic [11:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  task automatic offer(input logic [7:0] d, input logic pe, input logic pt,
                       input logic s2, input bit push, output int waited);
    int n = 0;
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    STOP2 = s2;
    DATA_VALID = 1'b1;
    while (READY !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 40) begin
      $display("FAIL ready_wait ready=%b want 1 within 40 cycles", READY);
    end else begin
      passes++;
      if (push) push_frame(d, pe, pt, s2);
    end
    waited = n;
  endtask

  task automatic wait_idle(output int busy_n);
    int n = 0;
    busy_n = 0;
    while (n < 60) begin
      if (BUSY === 1'b1) busy_n++;
      if (exp_q.size() == 0 && BUSY === 1'b0) break;
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 60) $display("FAIL idle_wait busy=%b still busy after 60 cycles", BUSY);
    else passes++;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    DATA_VALID = 1'b0;
    P_DATA = 8'h00;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    STOP2 = 1'b0;
    #3;
    checks++;
    if ({TX_OUT, ser_en, BUSY, READY, FRAME_ERR} !== 5'b10010)
      $display("FAIL reset_outs tx,en,busy,rdy,err=%b want 10010",
               {TX_OUT, ser_en, BUSY, READY, FRAME_ERR});
    else passes++;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({TX_OUT, BUSY, READY} !== 3'b101)
      $display("FAIL post_reset tx,busy,rdy=%b want 101", {TX_OUT, BUSY, READY});
    else passes++;
  endtask

  task automatic test_basic;
    int n;
    logic [11:0] v;
    checks++;
    if (READY !== 1'b1) $display("FAIL basic_ready ready=%b want 1", READY);
    else passes++;
    P_DATA = 8'hA5;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    STOP2 = 1'b0;
    DATA_VALID = 1'b1;
    v = 12'b00_1101001010;
    push_bits(v, 10);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_idle(n);
    checks++;
    if (n != 10) $display("FAIL basic_len busy=%0d want 10", n);
    else passes++;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_parity;
    int n;
    int w;
    for (int pt = 0; pt < 2; pt++) begin
      offer(8'hA5, 1'b1, pt[0], 1'b0, 1'b1, w);
      @(negedge CLK);
      DATA_VALID = 1'b0;
      wait_idle(n);
      checks++;
      if (n != 11) $display("FAIL parity_len pt=%0d busy=%0d want 11", pt, n);
      else passes++;
    end
  endtask

  task automatic test_cfg_hold;
    int n;
    logic [11:0] v;
    P_DATA = 8'h01;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b1;
    STOP2 = 1'b1;
    DATA_VALID = 1'b1;
    v = 12'b110000000010;
    push_bits(v, 12);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    PAR_TYP = 1'b0;
    PAR_EN = 1'b0;
    STOP2 = 1'b0;
    wait_idle(n);
    checks++;
    if (n != 12) $display("FAIL cfg_len busy=%0d want 12", n);
    else passes++;
  endtask

  task automatic test_back_to_back;
    int n;
    int w;
    offer(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, w);
    @(negedge CLK);
    offer(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, w);
    checks++;
    if (w != 9 || TX_OUT !== 1'b1 || BUSY !== 1'b1)
      $display("FAIL b2b_ready_slot wait=%0d tx=%b busy=%b want 9 1 1",
               w, TX_OUT, BUSY);
    else passes++;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    checks++;
    if (READY !== 1'b0 || TX_OUT !== 1'b0)
      $display("FAIL b2b_start rdy=%b tx=%b want 0 0", READY, TX_OUT);
    else passes++;
    wait_idle(n);
    checks++;
    if (n != 10) $display("FAIL b2b_len busy=%0d want 10", n);
    else passes++;
  endtask

  task automatic test_timeout;
    int n;
    int w;
    mon_en = 1'b0;
    no_done = 1'b1;
    offer(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, w);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    n = 1;
    while (FRAME_ERR !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n != 12) $display("FAIL timeout_cycle at=%0d want 12", n);
    else passes++;
    checks++;
    if ({BUSY, TX_OUT, READY, ser_en} !== 4'b0110)
      $display("FAIL timeout_state busy,tx,rdy,en=%b want 0110",
               {BUSY, TX_OUT, READY, ser_en});
    else passes++;
    @(negedge CLK);
    checks++;
    if (FRAME_ERR !== 1'b0) $display("FAIL timeout_pulse err=%b want 0", FRAME_ERR);
    else passes++;
    no_done = 1'b0;
    mon_en = 1'b1;
    offer(8'h96, 1'b1, 1'b1, 1'b0, 1'b1, w);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_idle(n);
    checks++;
    if (n != 11) $display("FAIL timeout_next_len busy=%0d want 11", n);
    else passes++;
  endtask

  task automatic test_reset_mid;
    int n;
    int w;
    offer(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, w);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    mon_en = 1'b0;
    exp_q.delete();
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({TX_OUT, BUSY, ser_en, READY, FRAME_ERR} !== 5'b10010)
      $display("FAIL mid_reset tx,busy,en,rdy,err=%b want 10010",
               {TX_OUT, BUSY, ser_en, READY, FRAME_ERR});
    else passes++;
    @(negedge CLK);
    RST = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);
    offer(8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, w);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_idle(n);
    checks++;
    if (n != 12) $display("FAIL mid_reset_next_len busy=%0d want 12", n);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_cfg_hold();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
